// File: rtl/eth_pkg.sv
// Shared definitions for the EtherType classifier.
//  - Well-known EtherType constants used as the default channel table.
//  - FSM state encoding for the classifier top level.
//  - Helper to size a channel index so that a single channel still gets one bit.
package eth_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
    localparam logic [15:0] ETHERTYPE_IPV6 = 16'h86DD;
    localparam logic [15:0] ETHERTYPE_VLAN = 16'h8100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/eth_type_match.sv
// Combinational EtherType table lookup with lowest-index priority.
// Ports:
//  i_type    in   16        EtherType of the header being offered
//  i_enable  in   M_COUNT   runtime per-channel enable mask
//  o_hit     out  1         at least one enabled entry matches
//  o_sel     out  SEL_W     lowest matching enabled channel index (0 when no hit)
module eth_type_match
    import eth_pkg::*;
#(
    parameter int                    M_COUNT       = 4,
    parameter logic [M_COUNT*16-1:0] ETH_TYPE_LIST = '0,
    parameter int                    SEL_W         = sel_width(M_COUNT)
)
(
    input  logic [15:0]        i_type,
    input  logic [M_COUNT-1:0] i_enable,
    output logic               o_hit,
    output logic [SEL_W-1:0]   o_sel
);

    logic [M_COUNT-1:0] w_match;

    always_comb begin
        for (int i = 0; i < M_COUNT; i++) begin
            w_match[i] = (ETH_TYPE_LIST[16*i +: 16] == i_type) && i_enable[i];
        end
    end

    // Scan from the top down so the last assignment, the lowest index,
    // wins when the table holds duplicate EtherTypes.
    always_comb begin
        o_hit = 1'b0;
        o_sel = '0;
        for (int i = M_COUNT - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                o_hit = 1'b1;
                o_sel = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/eth_type_classifier.sv
// N-way EtherType classifier and demux between the Ethernet RX framer and
// protocol engines. One frame is in flight at a time; the channel selection
// is taken at header accept and held until the frame completes. Frames with
// no enabled matching channel are drained and counted.
// Ports:
//  i_clk, i_rst                         clock, asynchronous active-high reset
//  i_s_eth_hdr_valid / o_s_eth_hdr_ready input header handshake
//  i_s_eth_dest_mac, i_s_eth_src_mac    input MACs (48 each)
//  i_s_eth_type                         input EtherType (16)
//  i_s_eth_payload_axis_*               input payload stream (tdata/tvalid/tlast/tuser, tready out)
//  o_m_eth_hdr_valid / i_m_eth_hdr_ready per-channel header handshake (M_COUNT)
//  o_m_eth_dest_mac/src_mac/type        registered header, shared by all channels
//  o_m_eth_payload_axis_tdata/tlast/tuser shared payload bus
//  o_m_eth_payload_axis_tvalid / i_m_eth_payload_axis_tready per-channel payload handshake
//  i_chan_enable                        runtime enable mask, sampled at header accept
//  o_drop_count                         saturating count of dropped frames
//  o_drop_pulse                         one-cycle strobe per dropped header
//  o_busy                               high whenever a frame is in progress
module eth_type_classifier
    import eth_pkg::*;
#(
    parameter int                    M_COUNT        = 4,
    parameter int                    DATA_WIDTH     = 8,
    parameter logic [M_COUNT*16-1:0] ETH_TYPE_LIST  = {ETHERTYPE_VLAN, ETHERTYPE_IPV6,
                                                       ETHERTYPE_ARP,  ETHERTYPE_IPV4},
    parameter int                    DROP_CNT_WIDTH = 16
)
(
    input  logic                      i_clk,
    input  logic                      i_rst,

    input  logic                      i_s_eth_hdr_valid,
    output logic                      o_s_eth_hdr_ready,
    input  logic [47:0]               i_s_eth_dest_mac,
    input  logic [47:0]               i_s_eth_src_mac,
    input  logic [15:0]               i_s_eth_type,
    input  logic [DATA_WIDTH-1:0]     i_s_eth_payload_axis_tdata,
    input  logic                      i_s_eth_payload_axis_tvalid,
    output logic                      o_s_eth_payload_axis_tready,
    input  logic                      i_s_eth_payload_axis_tlast,
    input  logic                      i_s_eth_payload_axis_tuser,

    output logic [M_COUNT-1:0]        o_m_eth_hdr_valid,
    input  logic [M_COUNT-1:0]        i_m_eth_hdr_ready,
    output logic [47:0]               o_m_eth_dest_mac,
    output logic [47:0]               o_m_eth_src_mac,
    output logic [15:0]               o_m_eth_type,
    output logic [DATA_WIDTH-1:0]     o_m_eth_payload_axis_tdata,
    output logic [M_COUNT-1:0]        o_m_eth_payload_axis_tvalid,
    input  logic [M_COUNT-1:0]        i_m_eth_payload_axis_tready,
    output logic                      o_m_eth_payload_axis_tlast,
    output logic                      o_m_eth_payload_axis_tuser,

    input  logic [M_COUNT-1:0]        i_chan_enable,
    output logic [DROP_CNT_WIDTH-1:0] o_drop_count,
    output logic                      o_drop_pulse,
    output logic                      o_busy
);

    localparam int SEL_W = sel_width(M_COUNT);

    state_t                    r_state;
    state_t                    w_state_next;

    logic [SEL_W-1:0]          r_sel;
    logic [M_COUNT-1:0]        r_hdr_valid;
    logic                      r_hdr_done;
    logic                      r_pay_done;
    logic [47:0]               r_dest_mac;
    logic [47:0]               r_src_mac;
    logic [15:0]               r_type;
    logic [DROP_CNT_WIDTH-1:0] r_drop_count;
    logic                      r_drop_pulse;

    logic                      w_hit;
    logic [SEL_W-1:0]          w_sel;
    logic [M_COUNT-1:0]        w_sel_oh;
    logic [M_COUNT-1:0]        w_hit_oh;
    logic                      w_hdr_acc;
    logic                      w_hdr_xfer;
    logic                      w_last_xfer;

    eth_type_match #(
        .M_COUNT       (M_COUNT),
        .ETH_TYPE_LIST (ETH_TYPE_LIST),
        .SEL_W         (SEL_W)
    ) u_match (
        .i_type   (i_s_eth_type),
        .i_enable (i_chan_enable),
        .o_hit    (w_hit),
        .o_sel    (w_sel)
    );

    always_comb begin
        for (int i = 0; i < M_COUNT; i++) begin
            w_sel_oh[i] = (r_sel == SEL_W'(i));
            w_hit_oh[i] = w_hit && (w_sel == SEL_W'(i));
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and handshakes. Once the last payload beat of the frame has
    // gone through, the payload path is closed while we wait for the header
    // to be taken, so the next frame's payload cannot slip onto this channel.
    always_comb begin
        w_state_next                = r_state;
        o_s_eth_hdr_ready           = 1'b0;
        o_s_eth_payload_axis_tready = 1'b0;
        o_m_eth_payload_axis_tvalid = '0;
        w_hdr_acc                   = 1'b0;
        w_hdr_xfer                  = 1'b0;
        w_last_xfer                 = 1'b0;

        case (r_state)
            ST_IDLE: begin
                o_s_eth_hdr_ready = 1'b1;
                if (i_s_eth_hdr_valid) begin
                    w_hdr_acc    = 1'b1;
                    w_state_next = w_hit ? ST_FWD : ST_DROP;
                end
            end

            ST_FWD: begin
                if (!r_pay_done) begin
                    o_m_eth_payload_axis_tvalid = w_sel_oh & {M_COUNT{i_s_eth_payload_axis_tvalid}};
                    o_s_eth_payload_axis_tready = |(w_sel_oh & i_m_eth_payload_axis_tready);
                end
                w_last_xfer = i_s_eth_payload_axis_tvalid && o_s_eth_payload_axis_tready &&
                              i_s_eth_payload_axis_tlast;
                w_hdr_xfer  = |(r_hdr_valid & i_m_eth_hdr_ready);
                if ((r_pay_done || w_last_xfer) && (r_hdr_done || w_hdr_xfer)) begin
                    w_state_next = ST_IDLE;
                end
            end

            ST_DROP: begin
                o_s_eth_payload_axis_tready = 1'b1;
                if (i_s_eth_payload_axis_tvalid && i_s_eth_payload_axis_tlast) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sel        <= '0;
            r_hdr_valid  <= '0;
            r_hdr_done   <= 1'b0;
            r_pay_done   <= 1'b0;
            r_dest_mac   <= '0;
            r_src_mac    <= '0;
            r_type       <= '0;
            r_drop_count <= '0;
            r_drop_pulse <= 1'b0;
        end else begin
            r_drop_pulse <= 1'b0;
            if (w_hdr_acc) begin
                if (w_hit) begin
                    r_sel       <= w_sel;
                    r_hdr_valid <= w_hit_oh;
                    r_hdr_done  <= 1'b0;
                    r_pay_done  <= 1'b0;
                    r_dest_mac  <= i_s_eth_dest_mac;
                    r_src_mac   <= i_s_eth_src_mac;
                    r_type      <= i_s_eth_type;
                end else begin
                    r_drop_pulse <= 1'b1;
                    if (r_drop_count != {DROP_CNT_WIDTH{1'b1}}) begin
                        r_drop_count <= r_drop_count + 1'b1;
                    end
                end
            end else if (r_state == ST_FWD) begin
                if (w_hdr_xfer) begin
                    r_hdr_valid <= '0;
                    r_hdr_done  <= 1'b1;
                end
                if (w_last_xfer) begin
                    r_pay_done <= 1'b1;
                end
            end
        end
    end

    assign o_m_eth_hdr_valid          = r_hdr_valid;
    assign o_m_eth_dest_mac           = r_dest_mac;
    assign o_m_eth_src_mac            = r_src_mac;
    assign o_m_eth_type               = r_type;
    assign o_m_eth_payload_axis_tdata = i_s_eth_payload_axis_tdata;
    assign o_m_eth_payload_axis_tlast = i_s_eth_payload_axis_tlast;
    assign o_m_eth_payload_axis_tuser = i_s_eth_payload_axis_tuser;
    assign o_drop_count               = r_drop_count;
    assign o_drop_pulse               = r_drop_pulse;
    assign o_busy                     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_eth_type_classifier.sv
// Randomised self-checking bench for eth_type_classifier. Expected channel
// selection and drop counting come from a table search model kept here.
module tb_eth_type_classifier;

    localparam int M   = 4;
    localparam int DW  = 8;
    localparam int DCW = 6;
    localparam logic [DCW-1:0] DCMAX = '1;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_hdr_valid, s_hdr_ready;
    logic [47:0]   s_dest, s_src;
    logic [15:0]   s_type;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid, s_tready, s_tlast, s_tuser;
    logic [M-1:0]  m_hdr_valid, m_hdr_ready;
    logic [47:0]   m_dest, m_src;
    logic [15:0]   m_type;
    logic [DW-1:0] m_tdata;
    logic [M-1:0]  m_tvalid, m_tready;
    logic          m_tlast, m_tuser;
    logic [M-1:0]  chan_enable;
    logic [DCW-1:0] drop_count;
    logic          drop_pulse, busy;

    int checks = 0;
    int passed = 0;

    // Channel table as the specification lists it, channel 0 first.
    logic [15:0] tbl [M] = '{16'h0800, 16'h0806, 16'h86DD, 16'h8100};
    int exp_drops = 0;

    // Observations gathered by drive_frame
    logic [M-1:0] obs_hdr_oh, obs_chan;
    logic [15:0]  obs_type;
    int obs_pulses, obs_end_c, obs_last_c;
    bit obs_multi, obs_data_bad, obs_timeout, obs_tready_low, obs_late_tvalid;

    always #5 clk = ~clk;

    eth_type_classifier #(
        .M_COUNT(M), .DATA_WIDTH(DW), .DROP_CNT_WIDTH(DCW)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_s_eth_hdr_valid(s_hdr_valid), .o_s_eth_hdr_ready(s_hdr_ready),
        .i_s_eth_dest_mac(s_dest), .i_s_eth_src_mac(s_src), .i_s_eth_type(s_type),
        .i_s_eth_payload_axis_tdata(s_tdata), .i_s_eth_payload_axis_tvalid(s_tvalid),
        .o_s_eth_payload_axis_tready(s_tready), .i_s_eth_payload_axis_tlast(s_tlast),
        .i_s_eth_payload_axis_tuser(s_tuser),
        .o_m_eth_hdr_valid(m_hdr_valid), .i_m_eth_hdr_ready(m_hdr_ready),
        .o_m_eth_dest_mac(m_dest), .o_m_eth_src_mac(m_src), .o_m_eth_type(m_type),
        .o_m_eth_payload_axis_tdata(m_tdata), .o_m_eth_payload_axis_tvalid(m_tvalid),
        .i_m_eth_payload_axis_tready(m_tready), .o_m_eth_payload_axis_tlast(m_tlast),
        .o_m_eth_payload_axis_tuser(m_tuser),
        .i_chan_enable(chan_enable), .o_drop_count(drop_count),
        .o_drop_pulse(drop_pulse), .o_busy(busy)
    );

    // Reference: lowest enabled table entry whose EtherType matches, or -1.
    function automatic int ref_channel(input logic [15:0] t, input logic [M-1:0] en);
        for (int i = 0; i < M; i++) begin
            if (tbl[i] == t && en[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [M-1:0] onehot(input int ch);
        logic [M-1:0] v;
        v = '0;
        if (ch >= 0) v[ch] = 1'b1;
        return v;
    endfunction

    function automatic int next_drops(input int d);
        return (d < int'(DCMAX)) ? d + 1 : d;
    endfunction

    // Drives one frame starting just after a clock edge with the DUT idle,
    // records what the DUT did. Sink header ready appears after hdr_delay cycles.
    task automatic drive_frame(input logic [15:0] typ, input int nbeats, input int hdr_delay,
                               input int stall_pct, input bit scramble);
        int c, beat;
        logic [DW-1:0] d;
        logic lu;
        obs_chan = '0; obs_multi = 0; obs_data_bad = 0; obs_timeout = 0;
        obs_tready_low = 0; obs_late_tvalid = 0; obs_pulses = 0; obs_end_c = -1; obs_last_c = -1;
        s_hdr_valid = 1'b1;
        s_type = typ;
        s_dest = {$urandom, $urandom};
        s_src  = {$urandom, $urandom};
        @(posedge clk); #1;
        s_hdr_valid = 1'b0;
        obs_hdr_oh = m_hdr_valid;
        obs_type   = m_type;
        obs_pulses += int'(drop_pulse);
        c = 0; beat = 0;
        while (1) begin
            if (scramble) chan_enable = M'($urandom);
            m_hdr_ready = (c >= hdr_delay) ? '1 : '0;
            m_tready    = (int'($urandom_range(99)) < stall_pct) ? '0 : '1;
            s_tvalid    = (beat < nbeats);
            d           = DW'($urandom);
            lu          = 1'($urandom);
            s_tdata     = d;
            s_tuser     = lu;
            s_tlast     = (beat == nbeats - 1);
            #2;
            if ($countones(m_hdr_valid) > 1 || $countones(m_tvalid) > 1) obs_multi = 1;
            if (beat >= nbeats && m_tvalid != '0) obs_late_tvalid = 1;
            obs_chan |= m_tvalid;
            if (s_tvalid && !s_tready) obs_tready_low = 1;
            if (s_tvalid && s_tready) begin
                if (m_tdata !== d || m_tuser !== lu || m_tlast !== s_tlast) obs_data_bad = 1;
                if (s_tlast) obs_last_c = c;
                beat++;
            end
            @(posedge clk); #1;
            obs_pulses += int'(drop_pulse);
            c++;
            if (beat == nbeats && !busy) begin
                obs_end_c = c;
                break;
            end
            if (c > 300) begin
                obs_timeout = 1;
                break;
            end
        end
        s_tvalid = 1'b0; s_tlast = 1'b0; m_hdr_ready = '0; m_tready = '0;
    endtask

    task automatic applyStimulus_idle();
        s_hdr_valid = 0; s_dest = '0; s_src = '0; s_type = '0; s_tdata = '0;
        s_tvalid = 0; s_tlast = 0; s_tuser = 0; m_hdr_ready = '0; m_tready = '0;
        chan_enable = '1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus_idle();
        #12;
        checks++; if (m_hdr_valid !== '0) $display("[TB] FAIL reset_hdr_valid: got %b want 0", m_hdr_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else passed++;
        checks++; if (drop_count !== '0 || drop_pulse !== 1'b0)
            $display("[TB] FAIL reset_drop: got cnt %0d pulse %b want 0 0", drop_count, drop_pulse); else passed++;
        checks++; if (m_type !== '0 || m_dest !== '0)
            $display("[TB] FAIL reset_hdr_regs: got type %h dest %h want 0", m_type, m_dest); else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (s_hdr_ready !== 1'b1 || s_tready !== 1'b0)
            $display("[TB] FAIL idle_ready: got hdr %b pay %b want 1 0", s_hdr_ready, s_tready); else passed++;
    endtask

    task automatic test_basic_fwd();
        chan_enable = '1;
        drive_frame(16'h0800, 4, 0, 0, 0);
        checks++; if (obs_hdr_oh !== 4'b0001) $display("[TB] FAIL ipv4_hdr_valid: got %b want 0001", obs_hdr_oh); else passed++;
        checks++; if (obs_type !== 16'h0800) $display("[TB] FAIL ipv4_hdr_type: got %h want 0800", obs_type); else passed++;
        checks++; if (obs_chan !== 4'b0001) $display("[TB] FAIL ipv4_payload_chan: got %b want 0001", obs_chan); else passed++;
        checks++; if (obs_end_c !== 4 || obs_timeout) $display("[TB] FAIL ipv4_end_cycle: got %0d want 4", obs_end_c); else passed++;
        checks++; if (obs_data_bad || obs_multi) $display("[TB] FAIL ipv4_data: got bad=%0d multi=%0d want 0 0", obs_data_bad, obs_multi); else passed++;
    endtask

    task automatic test_hdr_stall();
        chan_enable = '1;
        drive_frame(16'h0806, 4, 10, 0, 0);
        checks++; if (obs_hdr_oh !== 4'b0010) $display("[TB] FAIL arp_hdr_valid: got %b want 0010", obs_hdr_oh); else passed++;
        checks++; if (obs_last_c !== 3) $display("[TB] FAIL arp_payload_done: got cycle %0d want 3", obs_last_c); else passed++;
        checks++; if (obs_end_c !== 11 || obs_timeout) $display("[TB] FAIL arp_wait_hdr: got end %0d want 11", obs_end_c); else passed++;
        checks++; if (obs_late_tvalid || obs_chan !== 4'b0010)
            $display("[TB] FAIL arp_payload_chan: got %b late=%0d want 0010 0", obs_chan, obs_late_tvalid); else passed++;
    endtask

    task automatic test_drop();
        chan_enable = '1;
        drive_frame(16'h1234, 6, 0, 50, 0);
        exp_drops = next_drops(exp_drops);
        checks++; if (obs_tready_low) $display("[TB] FAIL drop_tready: got low beat want always 1"); else passed++;
        checks++; if (obs_chan !== '0 || obs_hdr_oh !== '0)
            $display("[TB] FAIL drop_no_valid: got tvalid %b hdr %b want 0 0", obs_chan, obs_hdr_oh); else passed++;
        checks++; if (drop_count !== DCW'(exp_drops)) $display("[TB] FAIL drop_count: got %0d want %0d", drop_count, exp_drops); else passed++;
        checks++; if (obs_pulses !== 1) $display("[TB] FAIL drop_pulse: got %0d want 1", obs_pulses); else passed++;
        checks++; if (obs_end_c !== 6 || obs_timeout) $display("[TB] FAIL drop_end: got %0d want 6", obs_end_c); else passed++;
    endtask

    task automatic test_enable_mask();
        chan_enable = 4'b1110;
        drive_frame(16'h0800, 3, 0, 0, 0);
        exp_drops = next_drops(exp_drops);
        checks++; if (obs_hdr_oh !== '0 || obs_pulses !== 1)
            $display("[TB] FAIL mask_drop: got hdr %b pulses %0d want 0 1", obs_hdr_oh, obs_pulses); else passed++;
        drive_frame(16'h86DD, 3, 1, 0, 0);
        checks++; if (obs_hdr_oh !== 4'b0100 || obs_chan !== 4'b0100)
            $display("[TB] FAIL mask_ipv6: got hdr %b pay %b want 0100 0100", obs_hdr_oh, obs_chan); else passed++;
        checks++; if (drop_count !== DCW'(exp_drops)) $display("[TB] FAIL mask_count: got %0d want %0d", drop_count, exp_drops); else passed++;
    endtask

    task automatic test_drop_saturate();
        chan_enable = '1;
        for (int n = 0; n < (1 << DCW) + 2; n++) begin
            drive_frame(16'hBEEF, 1, 0, 0, 0);
            exp_drops = next_drops(exp_drops);
        end
        checks++; if (drop_count !== DCMAX) $display("[TB] FAIL sat_count: got %0d want %0d", drop_count, DCMAX); else passed++;
        checks++; if (obs_pulses !== 1 || obs_timeout) $display("[TB] FAIL sat_pulse: got %0d want 1", obs_pulses); else passed++;
    endtask

    task automatic test_reset_midframe();
        chan_enable = '1;
        s_hdr_valid = 1'b1; s_type = 16'h8100;
        @(posedge clk); #1;
        s_hdr_valid = 1'b0;
        checkOutput_vlan: begin
            checks++; if (m_hdr_valid !== 4'b1000) $display("[TB] FAIL vlan_hdr_valid: got %b want 1000", m_hdr_valid); else passed++;
        end
        m_tready = '1;
        for (int b = 0; b < 3; b++) begin
            s_tvalid = 1'b1; s_tdata = DW'(b); s_tlast = 1'b0;
            if (b < 2) begin
                @(posedge clk); #1;
            end
        end
        #1;
        checks++; if (m_tvalid !== 4'b1000) $display("[TB] FAIL vlan_beat2: got %b want 1000", m_tvalid); else passed++;
        rst = 1'b1;
        #1;
        checks++; if (m_tvalid !== '0 || m_hdr_valid !== '0 || busy !== 1'b0)
            $display("[TB] FAIL rst_mid: got tvalid %b hdr %b busy %b want 0 0 0", m_tvalid, m_hdr_valid, busy); else passed++;
        exp_drops = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        s_tvalid = 1'b0; m_tready = '0;
        @(posedge clk); #1;
        drive_frame(16'h0800, 2, 0, 0, 0);
        checks++; if (obs_hdr_oh !== 4'b0001 || obs_end_c !== 2)
            $display("[TB] FAIL rst_recover: got hdr %b end %0d want 0001 2", obs_hdr_oh, obs_end_c); else passed++;
    endtask

    task automatic test_random();
        logic [15:0] t;
        logic [M-1:0] en;
        int ch;
        for (int n = 0; n < 24; n++) begin
            t  = ($urandom_range(4) == 4) ? 16'($urandom) : tbl[$urandom_range(M - 1)];
            en = M'($urandom);
            chan_enable = en;
            ch = ref_channel(t, en);
            drive_frame(t, 1 + int'($urandom_range(4)), int'($urandom_range(5)), 30, 1);
            if (ch < 0) exp_drops = next_drops(exp_drops);
            checks++; if (obs_hdr_oh !== onehot(ch))
                $display("[TB] FAIL rand_hdr[%0d]: type %h en %b got %b want %b", n, t, en, obs_hdr_oh, onehot(ch)); else passed++;
            checks++; if (obs_chan !== onehot(ch))
                $display("[TB] FAIL rand_pay[%0d]: got %b want %b", n, obs_chan, onehot(ch)); else passed++;
            checks++; if (obs_pulses !== ((ch < 0) ? 1 : 0) || drop_count !== DCW'(exp_drops))
                $display("[TB] FAIL rand_drop[%0d]: got pulses %0d cnt %0d want cnt %0d", n, obs_pulses, drop_count, exp_drops); else passed++;
            checks++; if (obs_timeout || obs_data_bad || obs_multi)
                $display("[TB] FAIL rand_flow[%0d]: got to=%0d bad=%0d multi=%0d want 0", n, obs_timeout, obs_data_bad, obs_multi); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_fwd();
        test_hdr_stall();
        test_drop();
        test_enable_mask();
        test_random();
        test_drop_saturate();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
